// File: rtl/keypad_encoder.sv
// 4x4 active-low keypad scanner: synchronises and debounces the rows and turns each
// accepted press into a single-cycle calculator key event.
module keypad_encoder #(
  parameter int SCAN_DIV     = 16,
  parameter int DEBOUNCE_CYC = 250000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic       is_num,
  output logic       is_op,
  output logic       is_eq,
  output logic       is_clr,
  output logic [3:0] num_val,
  output logic [1:0] op_val,
  output logic       key_down
);

  // state    | meaning
  // S_SCAN   | rotate columns, sample rows at the end of each column slot
  // S_DEBOUNCE | column held, waiting for the captured row to stay low
  // S_HOLD   | event issued, waiting for the captured row to stay high
  typedef enum logic [1:0] {S_SCAN, S_DEBOUNCE, S_HOLD} state_e;
  typedef enum logic [1:0] {K_NUM, K_OP, K_EQ, K_CLR} kind_e;

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int DEB_W = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYC - 1);

  state_e           state_q;
  logic [1:0]       col_idx_q;
  logic [DIV_W-1:0] div_cnt_q;
  logic [DEB_W-1:0] deb_cnt_q;
  logic [1:0]       r_cap_q;
  logic [1:0]       c_cap_q;
  logic [3:0]       row_m_q;
  logic [3:0]       row_s_q;

  logic [1:0] row_low_d;
  logic       row_any_d;
  logic       row_sel_d;
  kind_e      kind_d;
  logic [3:0] digit_d;

  assign col_n     = ~(4'b0001 << col_idx_q);
  assign row_any_d = (row_s_q != 4'hF);
  assign row_sel_d = row_s_q[r_cap_q];

  // lowest-index low row wins when several keys share a column
  always_comb begin
    row_low_d = 2'd3;
    if (!row_s_q[0])      row_low_d = 2'd0;
    else if (!row_s_q[1]) row_low_d = 2'd1;
    else if (!row_s_q[2]) row_low_d = 2'd2;
  end

  always_comb begin
    kind_d  = K_NUM;
    digit_d = 4'd0;
    if (c_cap_q == 2'd3) begin
      kind_d = K_OP;
    end else if (r_cap_q == 2'd3) begin
      case (c_cap_q)
        2'd0:    kind_d = K_CLR;
        2'd1:    digit_d = 4'd0;
        default: kind_d = K_EQ;
      endcase
    end else begin
      digit_d = {2'b00, r_cap_q} * 4'd3 + {2'b00, c_cap_q} + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_SCAN;
      col_idx_q <= 2'd0;
      div_cnt_q <= '0;
      deb_cnt_q <= '0;
      r_cap_q   <= 2'd0;
      c_cap_q   <= 2'd0;
      row_m_q   <= 4'hF;
      row_s_q   <= 4'hF;
      is_num    <= 1'b0;
      is_op     <= 1'b0;
      is_eq     <= 1'b0;
      is_clr    <= 1'b0;
      num_val   <= 4'd0;
      op_val    <= 2'd0;
      key_down  <= 1'b0;
    end else begin
      row_m_q <= row_n;
      row_s_q <= row_m_q;
      is_num  <= 1'b0;
      is_op   <= 1'b0;
      is_eq   <= 1'b0;
      is_clr  <= 1'b0;
      case (state_q)
        S_SCAN: begin
          if (div_cnt_q == DIV_LAST) begin
            div_cnt_q <= '0;
            if (!row_any_d) begin
              col_idx_q <= col_idx_q + 2'd1;
            end else begin
              r_cap_q   <= row_low_d;
              c_cap_q   <= col_idx_q;
              deb_cnt_q <= '0;
              state_q   <= S_DEBOUNCE;
            end
          end else begin
            div_cnt_q <= div_cnt_q + DIV_W'(1);
          end
        end
        S_DEBOUNCE: begin
          if (row_sel_d) begin
            state_q   <= S_SCAN;
            col_idx_q <= col_idx_q + 2'd1;
          end else if (deb_cnt_q == DEB_LAST) begin
            deb_cnt_q <= '0;
            state_q   <= S_HOLD;
            key_down  <= 1'b1;
            case (kind_d)
              K_NUM: begin
                is_num  <= 1'b1;
                num_val <= digit_d;
              end
              K_OP: begin
                is_op  <= 1'b1;
                op_val <= r_cap_q;
              end
              K_EQ:    is_eq  <= 1'b1;
              default: is_clr <= 1'b1;
            endcase
          end else begin
            deb_cnt_q <= deb_cnt_q + DEB_W'(1);
          end
        end
        S_HOLD: begin
          if (!row_sel_d) begin
            deb_cnt_q <= '0;
          end else if (deb_cnt_q == DEB_LAST) begin
            deb_cnt_q <= '0;
            state_q   <= S_SCAN;
            col_idx_q <= col_idx_q + 2'd1;
            key_down  <= 1'b0;
          end else begin
            deb_cnt_q <= deb_cnt_q + DEB_W'(1);
          end
        end
        default: state_q <= S_SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_encoder.sv
// Bench for keypad_encoder: a keypad matrix model drives the rows, and an event-level
// model (expected key events in order, plus held digit/operator) is checked every cycle.
module tb_keypad_encoder;
  localparam int SCAN_DIV = 4;
  localparam int DEB      = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] row_n, col_n;
  logic       is_num, is_op, is_eq, is_clr, key_down;
  logic [3:0] num_val;
  logic [1:0] op_val;
  logic [3:0][3:0] keys;

  keypad_encoder #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CYC(DEB)) dut (
    .clk(clk), .rst(rst), .row_n(row_n), .col_n(col_n),
    .is_num(is_num), .is_op(is_op), .is_eq(is_eq), .is_clr(is_clr),
    .num_val(num_val), .op_val(op_val), .key_down(key_down)
  );

  always #5 clk = ~clk;

  // pressed key shorts its row to its column when that column is driven low
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r][c] && !col_n[c]) row_n[r] = 1'b0;
  end

  typedef struct packed {
    logic [1:0] kind;  // 0 digit, 1 operator, 2 equals, 3 clear
    logic [3:0] val;
  } ev_t;

  ev_t        exp_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  longint     cyc      = 0;
  longint     last_pulse = -1000;
  logic [3:0] model_num = 4'd0;
  logic [1:0] model_op  = 2'd0;

  task automatic check(input bit ok, input string name, input int act, input int exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic ev_t key_ev(input int r, input int c);
    string km[4];
    byte   ch;
    ev_t   e;
    km = '{"123+", "456-", "789*", "C0=/"};
    ch = km[r].getc(c);
    e  = '0;
    if (ch >= "0" && ch <= "9") begin e.kind = 2'd0; e.val = 4'(ch - "0"); end
    else if (ch == "+") begin e.kind = 2'd1; e.val = 4'd0; end
    else if (ch == "-") begin e.kind = 2'd1; e.val = 4'd1; end
    else if (ch == "*") begin e.kind = 2'd1; e.val = 4'd2; end
    else if (ch == "/") begin e.kind = 2'd1; e.val = 4'd3; end
    else if (ch == "=") e.kind = 2'd2;
    else e.kind = 2'd3;
    return e;
  endfunction

  always @(posedge clk) cyc++;

  int         np;
  logic [1:0] k;
  ev_t        e_cur;
  always @(negedge clk) begin
    if (!rst) begin
      check({is_num, is_op, is_eq, is_clr} == 4'b0000, "pulse_in_reset",
            {is_num, is_op, is_eq, is_clr}, 0);
      check(col_n == 4'b1110, "col_in_reset", col_n, 4'b1110);
      check(num_val == 4'd0 && op_val == 2'd0, "vals_in_reset", {num_val, op_val}, 0);
      model_num  = 4'd0;
      model_op   = 2'd0;
      last_pulse = -1000;
    end else begin
      np = int'(is_num) + int'(is_op) + int'(is_eq) + int'(is_clr);
      check($countones(~col_n) == 1, "col_onehot", col_n, 1);
      check(np <= 1, "pulse_exclusive", np, 1);
      if (np != 0) begin
        if (is_num)     k = 2'd0;
        else if (is_op) k = 2'd1;
        else if (is_eq) k = 2'd2;
        else            k = 2'd3;
        check(exp_q.size() != 0, "unexpected_pulse", k, -1);
        check(cyc - last_pulse >= DEB, "pulse_spacing", int'(cyc - last_pulse), DEB);
        last_pulse = cyc;
        if (exp_q.size() != 0) begin
          e_cur = exp_q.pop_front();
          check(k == e_cur.kind, "event_kind", k, e_cur.kind);
          if (e_cur.kind == 2'd0) model_num = e_cur.val;
          if (e_cur.kind == 2'd1) model_op  = e_cur.val[1:0];
        end
      end
      check(num_val == model_num, "num_val_model", num_val, model_num);
      check(op_val == model_op, "op_val_model", op_val, model_op);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_events(input int budget, input string name);
    int i = 0;
    while (exp_q.size() != 0 && i < budget) begin
      step(1);
      i++;
    end
    check(exp_q.size() == 0, name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic press_release(input int r, input int c, input int hold);
    exp_q.push_back(key_ev(r, c));
    keys[r][c] = 1'b1;
    wait_events(60, "event_arrival");
    step(hold);
    check(key_down == 1'b1, "key_down_hold", key_down, 1);
    keys[r][c] = 1'b0;
    step(40);
    check(key_down == 1'b0, "key_down_release", key_down, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [3:0] rot[4];
  logic [3:0] prev;
  int         trans;
  int         seq_r[5];
  int         seq_c[5];
  int         wi;

  initial begin
    keys = '0;
    rot  = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
    seq_r = '{0, 0, 0, 0, 3};
    seq_c = '{0, 1, 3, 2, 2};
    #1 rst = 1'b0;

    // 1: reset values and idle column rotation
    step(3);
    check(col_n == 4'b1110, "rst_col_n", col_n, 4'b1110);
    check({is_num, is_op, is_eq, is_clr} == 4'b0, "rst_pulses", {is_num, is_op, is_eq, is_clr}, 0);
    check(num_val == 4'd0, "rst_num_val", num_val, 0);
    check(op_val == 2'd0, "rst_op_val", op_val, 0);
    check(key_down == 1'b0, "rst_key_down", key_down, 0);
    rst = 1'b1;
    prev  = col_n;
    trans = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (col_n != prev) begin
        if (trans < 4) check(col_n == rot[trans], "col_rotation", col_n, rot[trans]);
        trans++;
        prev = col_n;
      end
    end
    check(trans == 5, "col_dwell", trans, 5);
    step(180);

    // 2: hold '7', then press it again
    press_release(2, 0, 170);
    check(num_val == 4'd7, "num_val_7", num_val, 7);
    press_release(2, 0, 10);

    // 3: '/', '=', 'C'
    press_release(3, 3, 10);
    check(op_val == 2'b11, "op_val_div", op_val, 3);
    press_release(3, 2, 10);
    press_release(3, 0, 10);
    check(num_val == 4'd7, "num_val_kept", num_val, 7);

    // 4: bouncing '5'
    for (int i = 0; i < 10; i++) begin
      keys[1][1] = 1'b1;
      step(3);
      keys[1][1] = 1'b0;
      step(2);
    end
    exp_q.push_back(key_ev(1, 1));
    keys[1][1] = 1'b1;
    wait_events(60, "bounce_event_arrival");
    step(10);
    keys[1][1] = 1'b0;
    step(40);
    check(num_val == 4'd5, "num_val_5", num_val, 5);

    // 5: '1' and '4' together, then '9' during hold
    exp_q.push_back(key_ev(0, 0));
    keys[0][0] = 1'b1;
    keys[1][0] = 1'b1;
    wait_events(60, "multi_event_arrival");
    check(num_val == 4'd1, "num_val_1", num_val, 1);
    keys[2][2] = 1'b1;
    step(60);
    keys[2][2] = 1'b0;
    step(5);
    keys[0][0] = 1'b0;
    keys[1][0] = 1'b0;
    step(40);
    check(key_down == 1'b0, "multi_release", key_down, 0);

    // 6: 1 2 + 3 =
    for (int i = 0; i < 5; i++) press_release(seq_r[i], seq_c[i], 5);
    check(num_val == 4'd3, "seq_num_val", num_val, 3);
    check(op_val == 2'b00, "seq_op_val", op_val, 0);

    // reset while debouncing '3' (r0,c2)
    wi = 0;
    while (col_n[2] == 1'b0 && wi < 100) begin step(1); wi++; end
    keys[0][2] = 1'b1;
    wi = 0;
    while (col_n[2] != 1'b0 && wi < 100) begin step(1); wi++; end
    check(col_n == 4'b1011, "col2_reached", col_n, 4'b1011);
    step(7);
    check(col_n == 4'b1011, "held_in_debounce", col_n, 4'b1011);
    rst = 1'b0;
    step(3);
    check(key_down == 1'b0, "rst_mid_key_down", key_down, 0);
    keys[0][2] = 1'b0;
    rst = 1'b1;
    step(60);
    press_release(0, 2, 5);
    check(num_val == 4'd3, "post_rst_num_val", num_val, 3);

    step(10);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
